// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: FSM encodings, default
// geometry, lane count and the byte parity helper.
package dmem_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int LANES          = DEF_DATA_WIDTH / 8;

   // Even parity: the stored bit makes the total number of ones even.
   function automatic logic even_par8(input logic [7:0] byte_i);
      return ^byte_i;
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory
// controller (slave).
interface data_mem_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_be;
   logic                    rsp_valid;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_err;
   logic                    init_done;
   logic                    rsp_perr;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done, rsp_perr
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done, rsp_perr
   );
endinterface

// File: rtl/data_mem_ctrl_ram_array.sv
// DEPTH x DATA_WIDTH storage with per-lane synchronous write and a registered
// read port; parity columns exist only when DATA_MEM_CTRL_PARITY_EN is defined.
module dmem_ram_array
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wbe_i,
   input  logic                    re_i,
   input  logic                    rzero_i,
   input  logic [ADDR_WIDTH-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    rperr_o
);
   localparam int LN = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Byte-lane write into the array.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LN; i++) begin
         if (we_i && wbe_i[i]) begin
            mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   // Read register doubles as the response data; it holds between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
      end else begin
         rdata_q <= rdata_q;
      end
   end

   assign rdata_o = rdata_q;

`ifdef DATA_MEM_CTRL_PARITY_EN
   logic [LN-1:0] par_q [DEPTH];
   logic [LN-1:0] wpar_s;
   logic [LN-1:0] rpar_s;
   logic          rperr_q;

   // Parity of incoming write lanes and of the word currently addressed for read.
   always_comb begin
      wpar_s = '0;
      rpar_s = '0;
      for (int i = 0; i < LN; i++) begin
         wpar_s[i] = even_par8(wdata_i[8*i +: 8]);
         rpar_s[i] = even_par8(mem_q[raddr_i][8*i +: 8]);
      end
   end

   // Parity column written alongside its lane.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LN; i++) begin
         if (we_i && wbe_i[i]) begin
            par_q[waddr_i][i] <= wpar_s[i];
         end
      end
   end

   // Mismatch flag registered with the read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rperr_q <= 1'b0;
      end else if (re_i) begin
         rperr_q <= rzero_i ? 1'b0 : |(rpar_s ^ par_q[raddr_i]);
      end else begin
         rperr_q <= rperr_q;
      end
   end

   assign rperr_o = rperr_q;
`else
   assign rperr_o = 1'b0;
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: post-reset clear FSM, range check and read response
// pipeline around dmem_ram_array. Optional parity: DATA_MEM_CTRL_PARITY_EN.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = 256
) (
   input  logic          clk,
   input  logic          rst,
   data_mem_ctrl_if.slave bus
);
   localparam int LN = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH + 1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

   state_e                state_q;
   logic [ADDR_WIDTH:0]   clr_cnt_q;
   logic                  req_ready_q;
   logic                  init_done_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;

   logic                  accept_s;
   logic                  oor_s;
   logic                  ram_we_s;
   logic [ADDR_WIDTH-1:0] ram_waddr_s;
   logic [DATA_WIDTH-1:0] ram_wdata_s;
   logic [LN-1:0]         ram_wbe_s;
   logic                  ram_re_s;
   logic [DATA_WIDTH-1:0] ram_rdata_s;
   logic                  ram_rperr_s;

   // Write port is owned by the clear sequence until RUN.
   always_comb begin
      accept_s    = bus.req_valid && req_ready_q;
      oor_s       = ({1'b0, bus.req_addr} >= DEPTH_W);
      ram_re_s    = accept_s && !bus.req_we;
      ram_we_s    = 1'b0;
      ram_waddr_s = '0;
      ram_wdata_s = '0;
      ram_wbe_s   = '0;
      if (state_q == ST_CLEAR) begin
         ram_we_s    = 1'b1;
         ram_waddr_s = clr_cnt_q[ADDR_WIDTH-1:0];
         ram_wdata_s = '0;
         ram_wbe_s   = '1;
      end else begin
         ram_we_s    = accept_s && bus.req_we && !oor_s;
         ram_waddr_s = bus.req_addr;
         ram_wdata_s = bus.req_wdata;
         ram_wbe_s   = bus.req_be;
      end
   end

   // Clear/run FSM with registered handshake and response flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         clr_cnt_q   <= '0;
         req_ready_q <= 1'b0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= accept_s && !bus.req_we;
         rsp_err_q   <= accept_s && oor_s;
         case (state_q)
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + ONE_W;
               if (clr_cnt_q == LAST_W) begin
                  state_q     <= ST_RUN;
                  req_ready_q <= 1'b1;
                  init_done_q <= 1'b1;
               end else begin
                  state_q     <= ST_CLEAR;
                  req_ready_q <= 1'b0;
                  init_done_q <= 1'b0;
               end
            end
            ST_RUN: begin
               state_q     <= ST_RUN;
               req_ready_q <= 1'b1;
               init_done_q <= 1'b1;
            end
            default: begin
               state_q     <= ST_CLEAR;
               clr_cnt_q   <= '0;
               req_ready_q <= 1'b0;
               init_done_q <= 1'b0;
            end
         endcase
      end
   end

   dmem_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ram_we_s),
      .waddr_i (ram_waddr_s),
      .wdata_i (ram_wdata_s),
      .wbe_i   (ram_wbe_s),
      .re_i    (ram_re_s),
      .rzero_i (oor_s),
      .raddr_i (bus.req_addr),
      .rdata_o (ram_rdata_s),
      .rperr_o (ram_rperr_s)
   );

   assign bus.req_ready = req_ready_q;
   assign bus.init_done = init_done_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = ram_rdata_s;
   assign bus.rsp_perr  = ram_rperr_s;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a DEPTH=256 and a DEPTH=200 instance.
module tb_data_mem_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   data_mem_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if_a ();
   data_mem_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if_b ();

   data_mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256)) dut_a (
      .clk (clk), .rst (rst), .bus (if_a)
   );
   data_mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200)) dut_b (
      .clk (clk), .rst (rst), .bus (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request cycle on instance sel (0 = A, 1 = B); returns at the next negedge.
   task automatic drive(input bit sel, input logic we, input logic [7:0] addr,
                        input logic [15:0] wd, input logic [1:0] be);
      if (sel == 1'b0) begin
         if_a.req_valid = 1'b1; if_a.req_we = we; if_a.req_addr = addr;
         if_a.req_wdata = wd;   if_a.req_be = be;
      end else begin
         if_b.req_valid = 1'b1; if_b.req_we = we; if_b.req_addr = addr;
         if_b.req_wdata = wd;   if_b.req_be = be;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      if_a.req_valid = 1'b0;
      if_b.req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic rsp_chk(input bit sel, input string tag, input logic ev,
                          input logic [15:0] ed, input logic ee);
      if (sel == 1'b0) begin
         chk({tag, "_valid"}, {31'd0, if_a.rsp_valid}, {31'd0, ev});
         chk({tag, "_data"},  {16'd0, if_a.rsp_rdata}, {16'd0, ed});
         chk({tag, "_err"},   {31'd0, if_a.rsp_err},   {31'd0, ee});
         chk({tag, "_perr"},  {31'd0, if_a.rsp_perr},  32'd0);
      end else begin
         chk({tag, "_valid"}, {31'd0, if_b.rsp_valid}, {31'd0, ev});
         chk({tag, "_data"},  {16'd0, if_b.rsp_rdata}, {16'd0, ed});
         chk({tag, "_err"},   {31'd0, if_b.rsp_err},   {31'd0, ee});
         chk({tag, "_perr"},  {31'd0, if_b.rsp_perr},  32'd0);
      end
   endtask

   // Counts sampled cycles with req_ready low, starting at the release negedge.
   task automatic count_clear(output int na, output int nb);
      na = 0;
      nb = 0;
      for (int k = 0; k < 2000; k++) begin
         if (!if_a.req_ready) na++;
         if (!if_b.req_ready) nb++;
         if (if_a.req_ready && if_b.req_ready) break;
         @(negedge clk);
      end
   endtask

   int na;
   int nb;
   logic [15:0] tmp;

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      if_a.req_valid = 1'b0; if_a.req_we = 1'b0; if_a.req_addr = 8'h00;
      if_a.req_wdata = 16'h0000; if_a.req_be = 2'b00;
      if_b.req_valid = 1'b0; if_b.req_we = 1'b0; if_b.req_addr = 8'h00;
      if_b.req_wdata = 16'h0000; if_b.req_be = 2'b00;
      repeat (3) @(negedge clk);

      chk("rst_ready",  {31'd0, if_a.req_ready}, 32'd0);
      chk("rst_init",   {31'd0, if_a.init_done}, 32'd0);
      chk("rst_rvalid", {31'd0, if_a.rsp_valid}, 32'd0);
      chk("rst_rdata",  {16'd0, if_a.rsp_rdata}, 32'd0);
      chk("rst_err",    {31'd0, if_a.rsp_err},   32'd0);
      chk("rst_perr",   {31'd0, if_a.rsp_perr},  32'd0);

      rst = 1'b0;
      count_clear(na, nb);
      chk("clr_len_a", na, 32'd256);
      chk("clr_len_b", nb, 32'd200);
      chk("init_a", {31'd0, if_a.init_done}, 32'd1);
      chk("init_b", {31'd0, if_b.init_done}, 32'd1);

      drive(1'b0, 1'b0, 8'h7F, 16'h0000, 2'b00);
      rsp_chk(1'b0, "rd_7f", 1'b1, 16'h0000, 1'b0);
      idle();
      chk("rsp_pulse", {31'd0, if_a.rsp_valid}, 32'd0);

      drive(1'b0, 1'b1, 8'h10, 16'hABCD, 2'b11);
      chk("wr_no_rsp", {31'd0, if_a.rsp_valid}, 32'd0);
      drive(1'b0, 1'b1, 8'h10, 16'h1234, 2'b01);
      drive(1'b0, 1'b0, 8'h10, 16'h0000, 2'b00);
      rsp_chk(1'b0, "rd_10_lo", 1'b1, 16'hAB34, 1'b0);
      drive(1'b0, 1'b1, 8'h10, 16'hFFFF, 2'b00);
      drive(1'b0, 1'b1, 8'h10, 16'h5600, 2'b10);
      drive(1'b0, 1'b0, 8'h10, 16'h0000, 2'b00);
      rsp_chk(1'b0, "rd_10_hi", 1'b1, 16'h5634, 1'b0);
      idle();
      chk("hold_valid", {31'd0, if_a.rsp_valid}, 32'd0);
      chk("hold_data",  {16'd0, if_a.rsp_rdata}, 32'h5634);

      drive(1'b0, 1'b1, 8'h01, 16'h0101, 2'b11);
      drive(1'b0, 1'b1, 8'h02, 16'h0202, 2'b11);
      drive(1'b0, 1'b1, 8'h03, 16'h0303, 2'b11);
      drive(1'b0, 1'b1, 8'hFF, 16'hC3A5, 2'b11);
      drive(1'b0, 1'b0, 8'h01, 16'h0000, 2'b00);
      rsp_chk(1'b0, "b2b_1", 1'b1, 16'h0101, 1'b0);
      drive(1'b0, 1'b0, 8'h02, 16'h0000, 2'b00);
      rsp_chk(1'b0, "b2b_2", 1'b1, 16'h0202, 1'b0);
      drive(1'b0, 1'b0, 8'h03, 16'h0000, 2'b00);
      rsp_chk(1'b0, "b2b_3", 1'b1, 16'h0303, 1'b0);
      drive(1'b0, 1'b0, 8'hFF, 16'h0000, 2'b00);
      rsp_chk(1'b0, "rd_top_a", 1'b1, 16'hC3A5, 1'b0);
      idle();

      drive(1'b1, 1'b1, 8'hC7, 16'hBEEF, 2'b11);
      drive(1'b1, 1'b1, 8'hC8, 16'h1111, 2'b11);
      chk("oor_wr_err",   {31'd0, if_b.rsp_err},   32'd1);
      chk("oor_wr_valid", {31'd0, if_b.rsp_valid}, 32'd0);
      idle();
      chk("oor_wr_pulse", {31'd0, if_b.rsp_err}, 32'd0);
      drive(1'b1, 1'b0, 8'hC7, 16'h0000, 2'b00);
      rsp_chk(1'b1, "rd_c7", 1'b1, 16'hBEEF, 1'b0);
      drive(1'b1, 1'b0, 8'hC8, 16'h0000, 2'b00);
      rsp_chk(1'b1, "rd_c8", 1'b1, 16'h0000, 1'b1);
      drive(1'b1, 1'b0, 8'hC7, 16'h0000, 2'b00);
      rsp_chk(1'b1, "rd_c7_again", 1'b1, 16'hBEEF, 1'b0);
      drive(1'b1, 1'b0, 8'hFF, 16'h0000, 2'b00);
      rsp_chk(1'b1, "rd_ff_b", 1'b1, 16'h0000, 1'b1);
      idle();

`ifdef DATA_MEM_CTRL_PARITY_EN
      drive(1'b0, 1'b1, 8'h20, 16'h00F0, 2'b11);
      idle();
      tmp = dut_a.u_ram.mem_q[32];
      dut_a.u_ram.mem_q[32] = tmp ^ 16'h0001;
      drive(1'b0, 1'b0, 8'h20, 16'h0000, 2'b00);
      chk("perr_flip", {31'd0, if_a.rsp_perr}, 32'd1);
      drive(1'b0, 1'b0, 8'h10, 16'h0000, 2'b00);
      chk("perr_clean", {31'd0, if_a.rsp_perr}, 32'd0);
      idle();
`endif

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("mid_clr_ready", {31'd0, if_a.req_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_clr_init", {31'd0, if_a.init_done}, 32'd0);
      @(negedge clk);
      if_a.req_valid = 1'b1; if_a.req_we = 1'b1; if_a.req_addr = 8'h05;
      if_a.req_wdata = 16'h5555; if_a.req_be = 2'b11;
      rst = 1'b0;
      count_clear(na, nb);
      if_a.req_valid = 1'b0;
      chk("clr_len_a2", na, 32'd256);
      drive(1'b0, 1'b0, 8'h05, 16'h0000, 2'b00);
      rsp_chk(1'b0, "ignored_wr", 1'b1, 16'h0000, 1'b0);
      drive(1'b0, 1'b0, 8'h10, 16'h0000, 2'b00);
      rsp_chk(1'b0, "recleared", 1'b1, 16'h0000, 1'b0);

      drive(1'b0, 1'b1, 8'h10, 16'h7777, 2'b11);
      if_a.req_we = 1'b0; if_a.req_addr = 8'h10;
      @(posedge clk);
      #1;
      rst = 1'b1;
      if_a.req_valid = 1'b0;
      #1;
      chk("abort_valid", {31'd0, if_a.rsp_valid}, 32'd0);
      chk("abort_data",  {16'd0, if_a.rsp_rdata}, 32'd0);
      chk("abort_ready", {31'd0, if_a.req_ready}, 32'd0);
      @(negedge clk);
      chk("abort_valid2", {31'd0, if_a.rsp_valid}, 32'd0);
      rst = 1'b0;
      count_clear(na, nb);
      chk("clr_len_a3", na, 32'd256);
      drive(1'b0, 1'b0, 8'h10, 16'h0000, 2'b00);
      rsp_chk(1'b0, "post_abort", 1'b1, 16'h0000, 1'b0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised single-port data memory for the MIPS datapath, successor to the fixed 256x16 store. It adds byte-lane write enables, a registered read with a valid/ready request handshake, a post-reset clear sequence, and out-of-range address detection for non-power-of-two depths. It sits between the MEM stage and the local RAM array.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, request address width in words.
DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block accepts a request this cycle.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  word address.
req_wdata  input  DATA_WIDTH  write data.
req_be  input  DATA_WIDTH/8  byte-lane write enables; bit i covers bits [8i+7:8i].
rsp_valid  output  1  read data valid; one-cycle pulse.
rsp_rdata  output  DATA_WIDTH  read data.
rsp_err  output  1  the accepted request addressed a word >= DEPTH; valid with rsp_valid for reads, pulses alone for writes.
init_done  output  1  clear sequence finished.
rsp_perr  output  1  parity error on read data (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high, all outputs are 0 and the FSM is in CLEAR with clr_cnt = 0. Array contents are not reset directly.
- FSM states:
  - CLEAR: writes 0 to word clr_cnt each cycle, then increments clr_cnt. After word DEPTH-1 is written, go to RUN. Duration is exactly DEPTH cycles after reset deasserts. req_ready = 0 and init_done = 0 throughout.
  - RUN: req_ready = 1 every cycle, init_done = 1. The FSM stays in RUN until rst.
- Request acceptance: a request is accepted when req_valid && req_ready at a rising edge. Requests presented while req_ready = 0 are ignored, not queued. The requester must hold them.
- Write (req_we = 1):
  - In-range: each byte lane with req_be[i] = 1 is updated at the accept edge; other lanes keep their value.
  - req_be = 0 is a legal no-op.
  - No rsp_valid is produced.
- Read (req_we = 0): rsp_valid = 1 and rsp_rdata = stored word in the cycle after acceptance (latency 1). rsp_rdata holds its value until the next read response; it is not cleared when rsp_valid drops.
- Back-to-back reads give one response per cycle, in order. There is no response backpressure.
- Write followed by a read of the same address in the next cycle returns the new data.
- Out of range (req_addr >= DEPTH):
  - Write: discarded; rsp_err pulses for 1 cycle after acceptance.
  - Read: rsp_valid = 1, rsp_rdata = 0, rsp_err = 1.
- Reset mid-operation: asserting rst in any state aborts it. Any pending rsp_valid is cancelled immediately, and CLEAR restarts from word 0 once rst drops.
- Address arithmetic: clr_cnt is ADDR_WIDTH+1 bits wide so the DEPTH = 2**ADDR_WIDTH terminal count does not wrap.

Optional Feature:
- Macro DATA_MEM_CTRL_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte lane, written alongside its lane (CLEAR writes parity 0).
  - On each read response, rsp_perr = 1 if any lane's recomputed parity mismatches. It is valid only with rsp_valid.
  - An out-of-range read forces rsp_perr = 0.
- When undefined: no parity storage is instantiated and rsp_perr is tied to 0.

Decomposition:
- Shared package/include dmem_pkg holds:
  - FSM state encodings ST_CLEAR and ST_RUN.
  - Default DATA_WIDTH/ADDR_WIDTH.
  - Byte-lane count constant LANES = DATA_WIDTH/8.
  - The even-parity helper function.
- One sub-module, dmem_ram_array: DEPTH x DATA_WIDTH storage with per-lane synchronous write and registered read, plus optional parity columns. data_mem_ctrl owns the FSM, range check and response pipeline.

Test Plan:
1. Reset release, DEPTH = 256: req_ready and init_done stay 0 for exactly 256 cycles, then go 1. A read of addr 0x7F then returns 0x0000 with rsp_valid one cycle later.
2. Write 0xABCD to addr 0x10 with be = 2'b11, then write 0x1234 with be = 2'b01, then read 0x10 -> rsp_rdata = 0xAB34 one cycle after the read accept.
3. Reads to 0x01, 0x02 and 0x03 on consecutive cycles (after writing 0x0101, 0x0202, 0x0303) -> three consecutive rsp_valid pulses carrying 0x0101, 0x0202, 0x0303.
4. DEPTH = 200: write to 0xC8 -> rsp_err pulse, no rsp_valid. Read 0xC8 -> rsp_valid = 1, rsp_rdata = 0, rsp_err = 1. Read 0xC7 -> rsp_err = 0.
5. rst asserted 50 cycles into CLEAR, and again in the cycle after a read accept -> outputs go 0 immediately, no rsp_valid appears, and a full DEPTH-cycle CLEAR follows each release.
6. With DATA_MEM_CTRL_PARITY_EN: force-flip one stored bit at addr 0x20 via a hierarchical poke, then read -> rsp_perr = 1. Read a clean addr -> rsp_perr = 0.
